// File: rtl/obi_wrr_arbiter_if.sv
// OBI request/response types and the bundled bus seen by obi_wrr_arbiter.
// Carries N master request/response pairs plus the single shared-slave pair.
package obi_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

interface obi_wrr_arbiter_if
  import obi_pkg::*;
#(
  parameter int unsigned N = 3
) ();
  obi_req_t  [N-1:0] master_req_i;
  obi_resp_t [N-1:0] master_resp_o;
  obi_req_t          slave_req_o;
  obi_resp_t         slave_resp_i;

  // environment side: masters and the shared slave model
  modport master (
    output master_req_i,
    output slave_resp_i,
    input  master_resp_o,
    input  slave_req_o
  );

  // arbiter side
  modport slave (
    input  master_req_i,
    input  slave_resp_i,
    output master_resp_o,
    output slave_req_o
  );
endinterface

// File: rtl/obi_wrr_arbiter.sv
// Weighted round-robin arbiter sharing one OBI slave among N masters.
// Ports: clk_i, rst_ni, weight_i, bus (N master req/resp, slave req/resp), outstanding_o.
module obi_wrr_arbiter
  import obi_pkg::*;
#(
  parameter int unsigned XBAR_NMASTER    = 3,
  parameter int unsigned WEIGHT_W        = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  localparam int unsigned IW =
    (XBAR_NMASTER > 1) ? $clog2(XBAR_NMASTER) : 1,
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1),
  localparam int unsigned PW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [XBAR_NMASTER*WEIGHT_W-1:0] weight_i,
  obi_wrr_arbiter_if.slave                 bus,
  output logic [OW-1:0]                    outstanding_o
);

  logic [IW-1:0]       ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] cnt_q, cnt_d;
  logic                lock_q, lock_d;
  logic [IW-1:0]       lidx_q, lidx_d;
  logic                init_q, init_d;
  logic [IW-1:0]       mem_q [MAX_OUTSTANDING];
  logic [IW-1:0]       mem_d [MAX_OUTSTANDING];
  logic [PW-1:0]       wp_q, wp_d;
  logic [PW-1:0]       rp_q, rp_d;
  logic [OW-1:0]       occ_q, occ_d;

  logic [XBAR_NMASTER-1:0] req_v;
  logic                    any;
  logic [IW-1:0]           sel;
  logic                    full;
  logic                    empty;
  logic                    sreq;
  logic                    hs;
  logic                    pop;
  logic [IW-1:0]           head;
  logic [WEIGHT_W-1:0]     w_sel;
  logic [WEIGHT_W-1:0]     w_ptr;

  function automatic logic [IW-1:0] nxt_idx(
    input logic [IW-1:0] x
  );
    if (x == IW'(XBAR_NMASTER - 1)) return '0;
    return x + IW'(1);
  endfunction

  function automatic logic [PW-1:0] nxt_ptr(
    input logic [PW-1:0] p
  );
    if (p == PW'(MAX_OUTSTANDING - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Cyclic scan from ptr: iterate backwards so
  // the smallest offset overwrites last.
  always_comb begin
    int idx;
    req_v = '0;
    for (int i = 0; i < XBAR_NMASTER; i++) begin
      req_v[i] = bus.master_req_i[i].req;
    end
    any = |req_v;
    sel = ptr_q;
    for (int k = XBAR_NMASTER - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % XBAR_NMASTER;
      if (req_v[idx]) sel = IW'(idx);
    end
    if (lock_q) sel = lidx_q;
  end

  assign full  = (occ_q == OW'(MAX_OUTSTANDING));
  assign empty = (occ_q == '0);
  assign head  = mem_q[rp_q];

  // init_q masks the first cycle out of reset
  assign sreq = init_q & any & ~full;
  assign hs   = sreq & bus.slave_resp_i.gnt;
  assign pop  = init_q & bus.slave_resp_i.rvalid
              & ~empty;

  always_comb begin
    bus.slave_req_o = '0;
    if (sreq) begin
      bus.slave_req_o     = bus.master_req_i[sel];
      bus.slave_req_o.req = 1'b1;
    end
  end

  always_comb begin
    bus.master_resp_o = '0;
    for (int i = 0; i < XBAR_NMASTER; i++) begin
      bus.master_resp_o[i].gnt =
        hs & (sel == IW'(i));
      bus.master_resp_o[i].rvalid =
        pop & (head == IW'(i));
      bus.master_resp_o[i].rdata =
        bus.slave_resp_i.rdata;
    end
  end

  // weight 0 behaves as weight 1
  always_comb begin
    w_sel = weight_i[int'(sel)*WEIGHT_W +: WEIGHT_W];
    w_ptr = weight_i[int'(ptr_q)*WEIGHT_W +: WEIGHT_W];
    if (w_sel == '0) w_sel = WEIGHT_W'(1);
    if (w_ptr == '0) w_ptr = WEIGHT_W'(1);
  end

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    lock_d = lock_q;
    lidx_d = lidx_q;
    init_d = 1'b1;
    mem_d  = mem_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    occ_d  = occ_q;

    if (hs) begin
      if (sel == ptr_q) begin
        if ({1'b0, cnt_q} + (WEIGHT_W+1)'(1)
            >= {1'b0, w_ptr}) begin
          ptr_d = nxt_idx(ptr_q);
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + WEIGHT_W'(1);
        end
      end else if (w_sel == WEIGHT_W'(1)) begin
        ptr_d = nxt_idx(sel);
        cnt_d = '0;
      end else begin
        ptr_d = sel;
        cnt_d = WEIGHT_W'(1);
      end
    end

    // Hold the slave request stable until granted
    if (hs) begin
      lock_d = 1'b0;
    end else if (sreq) begin
      lock_d = 1'b1;
      lidx_d = sel;
    end

    if (hs) begin
      mem_d[wp_q] = sel;
      wp_d        = nxt_ptr(wp_q);
    end
    if (pop) rp_d = nxt_ptr(rp_q);
    occ_d = occ_q + OW'(hs) - OW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q  <= '0;
      cnt_q  <= '0;
      lock_q <= 1'b0;
      lidx_q <= '0;
      init_q <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        mem_q[i] <= '0;
      end
      wp_q   <= '0;
      rp_q   <= '0;
      occ_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      cnt_q  <= cnt_d;
      lock_q <= lock_d;
      lidx_q <= lidx_d;
      init_q <= init_d;
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      occ_q  <= occ_d;
    end
  end

  assign outstanding_o = occ_q;

  // A response with nothing outstanding is a
  // slave protocol error; it is dropped.
  ap_rvalid_empty: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    !(init_q && bus.slave_resp_i.rvalid && empty)
  );

endmodule
